// File: rtl/uart_app_pkg.sv
// uart_app_pkg: shared state codes, command codes and protocol bytes for the UART app
package uart_app_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_HDR  = 3'd0;
  localparam state_t S_CMD  = 3'd1;
  localparam state_t S_ARG  = 3'd2;
  localparam state_t S_CHK  = 3'd3;
  localparam state_t S_RESP = 3'd4;
  localparam logic [7:0] CMD_SET    = 8'h01;
  localparam logic [7:0] CMD_TOGGLE = 8'h02;
  localparam logic [7:0] CMD_QUERY  = 8'h03;
  localparam logic [7:0] HDR = 8'hAA;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/uart_byte_timeout.sv
// uart_byte_timeout: inter-byte idle counter that pulses expire after TIMEOUT idle cycles
module uart_byte_timeout #(
  parameter logic [19:0] TIMEOUT = 20'd500_000
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [19:0] cnt;
  assign expire = en & ~clr & (cnt == TIMEOUT - 20'd1);
  always_ff @(posedge sys_clk)
    cnt <= (!rst_n || clr || !en || expire) ? '0 : cnt + 20'd1;
endmodule

// File: rtl/uart_led_cmd.sv
// uart_led_cmd: parses HDR/CMD/ARG/CHK frames, drives breath_en and answers each frame
module uart_led_cmd
  import uart_app_pkg::*;
#(
  parameter logic [19:0] TIMEOUT = 20'd500_000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       breath_en,
  output logic [7:0] err_cnt
);
  state_t     state;
  logic [7:0] cmd, arg;
  logic       expire, good;
  assign good = rx_data == (cmd ^ arg);
  uart_byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .clr(rx_valid),
    .en(state == S_CMD || state == S_ARG || state == S_CHK),
    .expire(expire)
  );
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state     <= S_HDR;
      breath_en <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      err_cnt   <= 8'h00;
      cmd       <= 8'h00;
      arg       <= 8'h00;
    end else begin
      case (state)
        S_HDR: if (rx_valid && rx_data == HDR) state <= S_CMD;
        S_CMD:
          if (rx_valid) begin
            cmd   <= rx_data;
            state <= S_ARG;
          end else if (expire) begin
            state   <= S_HDR;
            err_cnt <= sat_inc(err_cnt);
          end
        S_ARG:
          if (rx_valid) begin
            arg   <= rx_data;
            state <= S_CHK;
          end else if (expire) begin
            state   <= S_HDR;
            err_cnt <= sat_inc(err_cnt);
          end
        S_CHK:
          if (rx_valid) begin
            state    <= S_RESP;
            tx_valid <= 1'b1;
            if (good && cmd == CMD_SET) begin
              breath_en <= arg[0];
              tx_data   <= ACK;
            end else if (good && cmd == CMD_TOGGLE) begin
              breath_en <= ~breath_en;
              tx_data   <= ACK;
            end else if (good && cmd == CMD_QUERY) begin
              tx_data <= {7'b1000000, breath_en};
            end else begin
              tx_data <= NAK;
              err_cnt <= sat_inc(err_cnt);
            end
          end else if (expire) begin
            state   <= S_HDR;
            err_cnt <= sat_inc(err_cnt);
          end
        S_RESP:
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= S_HDR;
          end
        default: state <= S_HDR;
      endcase
    end
  end
endmodule
